// File: rtl/fw_intc_claim_pkg.sv
// Shared constants and sizing helpers for the claim/complete interrupt controller.
package fw_intc_claim_pkg;

  // Register word offsets on the Wishbone slave port
  localparam logic [1:0] OFS_ENABLE   = 2'd0;
  localparam logic [1:0] OFS_PENDING  = 2'd1;
  localparam logic [1:0] OFS_CLAIM    = 2'd2;
  localparam logic [1:0] OFS_COMPLETE = 2'd3;

  // Bus handshake states
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } bus_state_t;

  // Width of a source ID (0 = none, 1..n_srcs = source index + 1)
  function automatic int id_width(input int n_srcs);
    return $clog2(n_srcs + 1);
  endfunction

  // Width of a source index, kept at least one bit for the single-source case
  function automatic int idx_width(input int n_srcs);
    return (n_srcs > 1) ? $clog2(n_srcs) : 1;
  endfunction

endpackage

// File: rtl/fw_intc_claim_if.sv
// Wishbone-style register bus between the core and the interrupt controller.
interface fw_intc_claim_if;
  logic [1:0]  r_adr;
  logic [31:0] r_dat_w;
  logic [31:0] r_dat_r;
  logic        r_cyc;
  logic        r_stb;
  logic        r_we;
  logic        r_ack;

  modport master (
    output r_adr, r_dat_w, r_cyc, r_stb, r_we,
    input  r_dat_r, r_ack
  );

  modport slave (
    input  r_adr, r_dat_w, r_cyc, r_stb, r_we,
    output r_dat_r, r_ack
  );
endinterface

// File: rtl/fw_intc_rr_sel.sv
// Round-robin source picker: searches upward from ptr+1, wraps to 0, ptr last.
module fw_intc_rr_sel
  import fw_intc_claim_pkg::*;
#(
  parameter int N_SRCS = 8,
  parameter int IDXW   = idx_width(N_SRCS)
) (
  input  logic [N_SRCS-1:0] eligible,
  input  logic [IDXW-1:0]   ptr,
  output logic              valid,
  output logic [IDXW-1:0]   index
);

  // Candidates strictly above the pointer get first pick
  logic [N_SRCS-1:0] above;

  genvar gi;
  generate
    for (gi = 0; gi < N_SRCS; gi++) begin : g_above
      assign above[gi] = eligible[gi] && (IDXW'(gi) > ptr);
    end
  endgenerate

  // Lowest eligible overall is the wrap-around fallback; lowest above ptr overrides it
  always_comb begin
    valid = |eligible;
    index = '0;
    for (int i = N_SRCS - 1; i >= 0; i--) begin
      if (eligible[i]) index = IDXW'(i);
    end
    for (int i = N_SRCS - 1; i >= 0; i--) begin
      if (above[i]) index = IDXW'(i);
    end
  end

endmodule

// File: rtl/fw_intc_claim.sv
// Level-sensitive interrupt controller with claim/complete handshake and
// round-robin arbitration, exposed as four Wishbone registers.
module fw_intc_claim
  import fw_intc_claim_pkg::*;
#(
  parameter int N_SRCS = 8
) (
  input  logic              clock,
  input  logic              reset,
  fw_intc_claim_if.slave    bus,
  input  logic [N_SRCS-1:0] src,
  output logic              irq
);

  localparam int IDXW = idx_width(N_SRCS);
  localparam int IDW  = id_width(N_SRCS);

  bus_state_t        state_reg;
  logic              r_ack_reg;
  logic [31:0]       r_dat_r_reg;
  logic [N_SRCS-1:0] enable_reg;
  logic [N_SRCS-1:0] insvc_reg;
  logic [IDXW-1:0]   rr_ptr_reg;
  logic              irq_reg;

  logic [N_SRCS-1:0] eligible_next;
  logic [N_SRCS-1:0] claim_set;
  logic [N_SRCS-1:0] complete_clr;
  logic              sel_valid;
  logic [IDXW-1:0]   sel_index;
  logic [IDW-1:0]    claim_id;
  logic [31:0]       rd_data_next;
  logic              accept;

  assign eligible_next = src & enable_reg & ~insvc_reg;
  assign accept        = (state_reg == ST_IDLE) && bus.r_cyc && bus.r_stb;
  assign claim_id      = sel_valid ? (IDW'(sel_index) + IDW'(1)) : '0;

  fw_intc_rr_sel #(
    .N_SRCS (N_SRCS),
    .IDXW   (IDXW)
  ) u_rr_sel (
    .eligible (eligible_next),
    .ptr      (rr_ptr_reg),
    .valid    (sel_valid),
    .index    (sel_index)
  );

  // One-hot set mask for a claim and clear mask for a complete; a complete
  // only matches an in-service source whose ID equals the full 32-bit word
  genvar gi;
  generate
    for (gi = 0; gi < N_SRCS; gi++) begin : g_masks
      assign claim_set[gi]    = sel_valid && (sel_index == IDXW'(gi));
      assign complete_clr[gi] = insvc_reg[gi] && (bus.r_dat_w == 32'(gi + 1));
    end
  endgenerate

  // Read mux; writes return zero data
  always_comb begin
    rd_data_next = '0;
    if (!bus.r_we) begin
      case (bus.r_adr)
        OFS_ENABLE:  rd_data_next[N_SRCS-1:0] = enable_reg;
        OFS_PENDING: rd_data_next[N_SRCS-1:0] = eligible_next;
        OFS_CLAIM:   rd_data_next[IDW-1:0]    = claim_id;
        default:     rd_data_next             = '0;
      endcase
    end
  end

  // Bus FSM plus all register side effects, applied once on the accept edge
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      r_ack_reg   <= 1'b0;
      r_dat_r_reg <= '0;
      enable_reg  <= '0;
      insvc_reg   <= '0;
      rr_ptr_reg  <= IDXW'(N_SRCS - 1);
      irq_reg     <= 1'b0;
    end else begin
      irq_reg <= |eligible_next;
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            state_reg   <= ST_ACK;
            r_ack_reg   <= 1'b1;
            r_dat_r_reg <= rd_data_next;
            if (bus.r_we && bus.r_adr == OFS_ENABLE) begin
              enable_reg <= bus.r_dat_w[N_SRCS-1:0];
            end
            if (!bus.r_we && bus.r_adr == OFS_CLAIM && sel_valid) begin
              insvc_reg  <= insvc_reg | claim_set;
              rr_ptr_reg <= sel_index;
            end
            if (bus.r_we && bus.r_adr == OFS_COMPLETE) begin
              insvc_reg <= insvc_reg & ~complete_clr;
            end
          end
        end
        ST_ACK: begin
          state_reg <= ST_IDLE;
          r_ack_reg <= 1'b0;
        end
        default: begin
          state_reg <= ST_IDLE;
          r_ack_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.r_ack   = r_ack_reg;
  assign bus.r_dat_r = r_dat_r_reg;
  assign irq         = irq_reg;

endmodule

// File: tb/tb_fw_intc_claim.sv
// Bench for fw_intc_claim: register-access vector table plus hand sequences
// for round-robin, disable-while-in-service and reset-during-ack.
module tb_fw_intc_claim;

  localparam int N = 8;

  logic         clock = 1'b0;
  logic         reset;
  logic [N-1:0] src;
  logic         irq;

  fw_intc_claim_if bus ();

  fw_intc_claim #(.N_SRCS(N)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus),
    .src   (src),
    .irq   (irq)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  logic [31:0] sb_q[$];

  typedef struct {
    logic [7:0]  src;
    logic        we;
    logic [1:0]  adr;
    logic [31:0] wdat;
    logic [31:0] rexp;
    logic        irq_exp;
  } vec_t;

  vec_t vecs[31];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    src         = '0;
    bus.r_cyc   = 1'b0;
    bus.r_stb   = 1'b0;
    bus.r_we    = 1'b0;
    bus.r_adr   = '0;
    bus.r_dat_w = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("reset ack", 32'(bus.r_ack), 32'd0);
    check("reset rdat", bus.r_dat_r, 32'd0);
    check("reset irq", 32'(irq), 32'd0);
  endtask

  // One bus access; read expectations go through the scoreboard queue
  task automatic access(input logic we, input logic [1:0] adr, input logic [31:0] wdat,
                        input logic [31:0] rexp, input logic [7:0] srcv, input string tag);
    logic [31:0] want;
    @(negedge clock);
    src         = srcv;
    bus.r_cyc   = 1'b1;
    bus.r_stb   = 1'b1;
    bus.r_we    = we;
    bus.r_adr   = adr;
    bus.r_dat_w = wdat;
    if (!we) sb_q.push_back(rexp);
    @(posedge clock);
    #1;
    bus.r_cyc = 1'b0;
    bus.r_stb = 1'b0;
    bus.r_we  = 1'b0;
    check({tag, " ack"}, 32'(bus.r_ack), 32'd1);
    if (!we) begin
      want = sb_q.pop_front();
      check({tag, " rdata"}, bus.r_dat_r, want);
    end
    $display("txn %-10s we=%0d adr=%0d wdat=%08h rdat=%08h src=%02h", tag, we, adr, wdat,
             bus.r_dat_r, srcv);
    @(posedge clock);
    #1;
    check({tag, " ack_drop"}, 32'(bus.r_ack), 32'd0);
  endtask

  initial begin
    //            src    we    adr   wdat          rexp   irq
    vecs[0]  = '{8'h00, 1'b0, 2'd0, 32'h0,        32'h0, 1'b0};
    vecs[1]  = '{8'h00, 1'b0, 2'd1, 32'h0,        32'h0, 1'b0};
    vecs[2]  = '{8'h00, 1'b0, 2'd2, 32'h0,        32'h0, 1'b0};
    vecs[3]  = '{8'h00, 1'b0, 2'd3, 32'h0,        32'h0, 1'b0};
    vecs[4]  = '{8'h14, 1'b1, 2'd0, 32'hFF,       32'h0, 1'b1};
    vecs[5]  = '{8'h14, 1'b0, 2'd0, 32'h0,        32'hFF, 1'b1};
    vecs[6]  = '{8'h14, 1'b0, 2'd1, 32'h0,        32'h14, 1'b1};
    vecs[7]  = '{8'h14, 1'b0, 2'd2, 32'h0,        32'd3, 1'b1};
    vecs[8]  = '{8'h14, 1'b0, 2'd2, 32'h0,        32'd5, 1'b0};
    vecs[9]  = '{8'h14, 1'b0, 2'd2, 32'h0,        32'd0, 1'b0};
    vecs[10] = '{8'h14, 1'b0, 2'd1, 32'h0,        32'h0, 1'b0};
    vecs[11] = '{8'h14, 1'b1, 2'd3, 32'd0,        32'h0, 1'b0};
    vecs[12] = '{8'h14, 1'b1, 2'd3, 32'd9,        32'h0, 1'b0};
    vecs[13] = '{8'h14, 1'b1, 2'd3, 32'd4,        32'h0, 1'b0};
    vecs[14] = '{8'h14, 1'b0, 2'd1, 32'h0,        32'h0, 1'b0};
    vecs[15] = '{8'h14, 1'b0, 2'd2, 32'h0,        32'd0, 1'b0};
    vecs[16] = '{8'h14, 1'b1, 2'd3, 32'd3,        32'h0, 1'b1};
    vecs[17] = '{8'h14, 1'b0, 2'd1, 32'h0,        32'h04, 1'b1};
    vecs[18] = '{8'h14, 1'b0, 2'd2, 32'h0,        32'd3, 1'b0};
    vecs[19] = '{8'h14, 1'b1, 2'd3, 32'd5,        32'h0, 1'b1};
    vecs[20] = '{8'h14, 1'b0, 2'd2, 32'h0,        32'd5, 1'b0};
    vecs[21] = '{8'h14, 1'b1, 2'd3, 32'd3,        32'h0, 1'b1};
    vecs[22] = '{8'h14, 1'b1, 2'd3, 32'd5,        32'h0, 1'b1};
    vecs[23] = '{8'h14, 1'b0, 2'd1, 32'h0,        32'h14, 1'b1};
    vecs[24] = '{8'h14, 1'b1, 2'd0, 32'hFFFFFF0F, 32'h0, 1'b1};
    vecs[25] = '{8'h14, 1'b0, 2'd0, 32'h0,        32'h0F, 1'b1};
    vecs[26] = '{8'h14, 1'b0, 2'd1, 32'h0,        32'h04, 1'b1};
    vecs[27] = '{8'h00, 1'b0, 2'd1, 32'h0,        32'h0, 1'b0};
    vecs[28] = '{8'h00, 1'b1, 2'd0, 32'hFF,       32'h0, 1'b0};
    vecs[29] = '{8'h40, 1'b0, 2'd2, 32'h0,        32'd7, 1'b0};
    vecs[30] = '{8'h00, 1'b1, 2'd3, 32'd7,        32'h0, 1'b0};

    do_reset();

    // Register table: reset reads, claim order, bad completes, enable masking
    for (int i = 0; i < 31; i++) begin
      access(vecs[i].we, vecs[i].adr, vecs[i].wdat, vecs[i].rexp, vecs[i].src,
             $sformatf("vec%0d", i));
      check($sformatf("vec%0d irq", i), 32'(irq), 32'(vecs[i].irq_exp));
    end

    // irq follows src with exactly one cycle of latency
    @(negedge clock);
    src = 8'h01;
    #1;
    check("irq_lat before", 32'(irq), 32'd0);
    @(posedge clock);
    #1;
    check("irq_lat after", 32'(irq), 32'd1);

    // Round-robin between sources 0 and 7 from a fresh reset
    do_reset();
    access(1'b1, 2'd0, 32'hFF, 32'h0, 8'h81, "rr_en");
    for (int i = 0; i < 6; i++) begin
      logic [31:0] id;
      id = (i % 2 == 0) ? 32'd1 : 32'd8;
      access(1'b0, 2'd2, 32'h0, id, 8'h81, $sformatf("rr_clm%0d", i));
      access(1'b1, 2'd3, id, 32'h0, 8'h81, $sformatf("rr_cmp%0d", i));
    end

    // Source drops and is disabled while in service; complete still clears it
    do_reset();
    access(1'b1, 2'd0, 32'hFF, 32'h0, 8'h02, "dis_en");
    access(1'b0, 2'd2, 32'h0, 32'd2, 8'h02, "dis_clm");
    access(1'b1, 2'd0, 32'h0, 32'h0, 8'h00, "dis_off");
    access(1'b0, 2'd1, 32'h0, 32'h0, 8'h00, "dis_pnd0");
    access(1'b1, 2'd0, 32'hFF, 32'h0, 8'h02, "dis_on");
    access(1'b0, 2'd1, 32'h0, 32'h0, 8'h02, "dis_pnd1");
    access(1'b1, 2'd0, 32'h0, 32'h0, 8'h00, "dis_off2");
    access(1'b1, 2'd3, 32'd2, 32'h0, 8'h00, "dis_cmp");
    access(1'b1, 2'd0, 32'hFF, 32'h0, 8'h02, "dis_on2");
    access(1'b0, 2'd1, 32'h0, 32'h02, 8'h02, "dis_pnd2");

    // Reset arriving during the ack cycle of a claim read
    do_reset();
    access(1'b1, 2'd0, 32'hFF, 32'h0, 8'h01, "rst_en");
    @(negedge clock);
    bus.r_cyc = 1'b1;
    bus.r_stb = 1'b1;
    bus.r_we  = 1'b0;
    bus.r_adr = 2'd2;
    @(posedge clock);
    #1;
    bus.r_cyc = 1'b0;
    bus.r_stb = 1'b0;
    check("rst_mid ack", 32'(bus.r_ack), 32'd1);
    check("rst_mid rdat", bus.r_dat_r, 32'd1);
    reset = 1'b1;
    #1;
    check("rst_abort ack", 32'(bus.r_ack), 32'd0);
    check("rst_abort rdat", bus.r_dat_r, 32'd0);
    check("rst_abort irq", 32'(irq), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    access(1'b0, 2'd0, 32'h0, 32'h0, 8'h01, "rst_en_rd");
    access(1'b0, 2'd1, 32'h0, 32'h0, 8'h01, "rst_pnd0");
    access(1'b1, 2'd0, 32'h01, 32'h0, 8'h01, "rst_en1");
    access(1'b0, 2'd1, 32'h0, 32'h01, 8'h01, "rst_pnd1");
    access(1'b0, 2'd2, 32'h0, 32'd1, 8'h01, "rst_clm");

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
